// File: rtl/update_param.sv
// Child SA-interval update stage: takes (i, z, k, l) and the two Occ counts,
// computes the child parameters, then pushes the result downstream or drops it.
module update_param #(
  parameter logic [7:0] C_A = 8'd1,
  parameter logic [7:0] C_C = 8'd0,
  parameter logic [7:0] C_G = 8'd0,
  parameter logic [7:0] C_T = 8'd0,
  parameter int         W   = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         valid_in,
  output logic         ready_in,
  input  logic [4:0]   position,
  input  logic [11:0]  addr,
  input  logic [W-1:0] i_in,
  input  logic [W-1:0] z_in,
  input  logic [W-1:0] k_in,
  input  logic [W-1:0] l_in,
  input  logic [W-1:0] occ_k,
  input  logic [W-1:0] occ_l,
  output logic         valid_out,
  input  logic         ready_out,
  output logic [4:0]   position_out,
  output logic [11:0]  addr_out,
  output logic [W-1:0] i_out,
  output logic [W-1:0] z_out,
  output logic [W-1:0] k_out,
  output logic [W-1:0] l_out,
  output logic [7:0]   drop_cnt
);

  localparam logic [4:0] NONE        = 5'd0;
  localparam logic [4:0] A_MATCH     = 5'd1;
  localparam logic [4:0] A_SNP       = 5'd2;
  localparam logic [4:0] A_INSERTION = 5'd3;
  localparam logic [4:0] A_DELETION  = 5'd4;
  localparam logic [4:0] C_MATCH     = 5'd5;
  localparam logic [4:0] C_SNP       = 5'd6;
  localparam logic [4:0] C_INSERTION = 5'd7;
  localparam logic [4:0] C_DELETION  = 5'd8;
  localparam logic [4:0] G_MATCH     = 5'd9;
  localparam logic [4:0] G_SNP       = 5'd10;
  localparam logic [4:0] G_INSERTION = 5'd11;
  localparam logic [4:0] G_DELETION  = 5'd12;
  localparam logic [4:0] T_MATCH     = 5'd13;
  localparam logic [4:0] T_SNP       = 5'd14;
  localparam logic [4:0] T_INSERTION = 5'd15;
  localparam logic [4:0] T_DELETION  = 5'd16;
  localparam logic [4:0] STOP_1      = 5'd17;
  localparam logic [4:0] STOP_2      = 5'd18;

  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

  state_t state, state_next;

  logic [4:0]   pos_p0;
  logic [11:0]  addr_p0;
  logic [W-1:0] i_p0, z_p0, k_p0, l_p0, occ_k_p0, occ_l_p0;

  logic [W-1:0] cb;
  logic         op_ok, is_ins, dec_i, dec_z, drop;
  logic [W:0]   k9, l9;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  wire accept = valid_in && ready_in;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = CALC;
      CALC:    state_next = drop ? IDLE : HOLD;
      HOLD:    if (ready_out) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Stage p0: capture the accepted set
  always_ff @(posedge clk) begin
    if (state == IDLE && accept) begin
      pos_p0   <= position;
      addr_p0  <= addr;
      i_p0     <= i_in;
      z_p0     <= z_in;
      k_p0     <= k_in;
      l_p0     <= l_in;
      occ_k_p0 <= occ_k;
      occ_l_p0 <= occ_l;
    end
  end

  always_comb begin
    cb     = '0;
    op_ok  = 1'b1;
    is_ins = 1'b0;
    dec_i  = 1'b0;
    dec_z  = 1'b0;
    case (pos_p0)
      A_MATCH, A_SNP, A_INSERTION, A_DELETION: cb = C_A;
      C_MATCH, C_SNP, C_INSERTION, C_DELETION: cb = C_C;
      G_MATCH, G_SNP, G_INSERTION, G_DELETION: cb = C_G;
      T_MATCH, T_SNP, T_INSERTION, T_DELETION: cb = C_T;
      default: op_ok = 1'b0;
    endcase
    case (pos_p0)
      A_MATCH, C_MATCH, G_MATCH, T_MATCH: dec_i = 1'b1;
      A_SNP, C_SNP, G_SNP, T_SNP: begin
        dec_i = 1'b1;
        dec_z = 1'b1;
      end
      A_INSERTION, C_INSERTION, G_INSERTION, T_INSERTION: begin
        dec_i  = 1'b1;
        dec_z  = 1'b1;
        is_ins = 1'b1;
      end
      A_DELETION, C_DELETION, G_DELETION, T_DELETION: dec_z = 1'b1;
      default: ;
    endcase
    // Sums carry one extra bit so an interval past the table end is detectable.
    k9 = is_ins ? {1'b0, k_p0} : {1'b0, cb} + {1'b0, occ_k_p0} + {{W{1'b0}}, 1'b1};
    l9 = is_ins ? {1'b0, l_p0} : {1'b0, cb} + {1'b0, occ_l_p0};
    drop = !op_ok || (k9 > l9) || k9[W] || l9[W] ||
           (dec_i && i_p0 == '0) || (dec_z && z_p0 == '0);
  end

  // Stage p1: result register and handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready_in     <= 1'b0;
      valid_out    <= 1'b0;
      drop_cnt     <= '0;
      position_out <= '0;
      addr_out     <= '0;
      i_out        <= '0;
      z_out        <= '0;
      k_out        <= '0;
      l_out        <= '0;
    end else begin
      ready_in <= (state_next == IDLE);
      case (state)
        CALC: begin
          if (drop) begin
            drop_cnt <= sat_inc(drop_cnt);
          end else begin
            valid_out    <= 1'b1;
            position_out <= pos_p0;
            addr_out     <= addr_p0;
            k_out        <= k9[W-1:0];
            l_out        <= l9[W-1:0];
            i_out        <= dec_i ? i_p0 - 1'b1 : i_p0;
            z_out        <= dec_z ? z_p0 - 1'b1 : z_p0;
          end
        end
        HOLD: if (ready_out) valid_out <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_update_param.sv
// Bench for update_param: directed and random sets compared against an
// arithmetic reference model of the child-interval update and drop rules.
module tb_update_param;

  logic        clk = 0;
  logic        rst_n, valid_in, ready_in, valid_out, ready_out;
  logic [4:0]  position, position_out;
  logic [11:0] addr, addr_out;
  logic [7:0]  i_in, z_in, k_in, l_in, occ_k, occ_l;
  logic [7:0]  i_out, z_out, k_out, l_out, drop_cnt;

  int checks = 0;
  int errors = 0;

  // Position codes: 0 NONE, 1..16 = base*4 + op + 1 (base A,C,G,T; op MATCH,SNP,INS,DEL),
  // 17 STOP_1, 18 STOP_2, anything higher undefined.
  int cbase[4] = '{1, 10, 50, 200};

  int exp_drops = 0;
  int exp_pos = 0, exp_addr = 0, exp_i = 0, exp_z = 0, exp_k = 0, exp_l = 0;

  update_param #(.C_A(8'd1), .C_C(8'd10), .C_G(8'd50), .C_T(8'd200), .W(8)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_in(ready_in),
    .position(position), .addr(addr), .i_in(i_in), .z_in(z_in), .k_in(k_in),
    .l_in(l_in), .occ_k(occ_k), .occ_l(occ_l), .valid_out(valid_out),
    .ready_out(ready_out), .position_out(position_out), .addr_out(addr_out),
    .i_out(i_out), .z_out(z_out), .k_out(k_out), .l_out(l_out), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic void model(input int pos, input int i, input int z, input int k,
                                input int l, input int ok, input int ol,
                                output bit drop, output int ko, output int lo,
                                output int io, output int zo);
    int cb, op;
    drop = 0; ko = 0; lo = 0; io = 0; zo = 0;
    if (pos < 1 || pos > 16) begin
      drop = 1;
      return;
    end
    cb = cbase[(pos - 1) / 4];
    op = (pos - 1) % 4;
    if (op == 2) begin
      ko = k; lo = l;
    end else begin
      ko = cb + ok + 1; lo = cb + ol;
    end
    io = (op == 3) ? i : i - 1;
    zo = (op == 0) ? z : z - 1;
    if (ko > lo || ko > 255 || lo > 255 || io < 0 || zo < 0) drop = 1;
  endfunction

  task automatic run_set(input int pos, input int ad, input int i, input int z,
                         input int k, input int l, input int ok, input int ol,
                         input int bp);
    bit drop;
    int ko, lo, io, zo;
    model(pos, i, z, k, l, ok, ol, drop, ko, lo, io, zo);
    for (int n = 0; n < 10 && !ready_in; n++) @(negedge clk);
    chk("ready_wait", ready_in, 1);
    position = pos[4:0]; addr = ad[11:0];
    i_in = i[7:0]; z_in = z[7:0]; k_in = k[7:0]; l_in = l[7:0];
    occ_k = ok[7:0]; occ_l = ol[7:0];
    valid_in = 1;
    ready_out = (bp == 0);
    @(negedge clk);
    valid_in = 0;
    chk("calc_ready", ready_in, 0);
    chk("calc_valid", valid_out, 0);
    @(negedge clk);
    if (drop) begin
      exp_drops = (exp_drops < 255) ? exp_drops + 1 : 255;
      chk("drop_valid", valid_out, 0);
      chk("drop_cnt", drop_cnt, exp_drops);
      chk("drop_ready", ready_in, 1);
      chk("drop_hold_k", k_out, exp_k);
      chk("drop_hold_addr", addr_out, exp_addr);
    end else begin
      exp_pos = pos; exp_addr = ad; exp_i = io; exp_z = zo; exp_k = ko; exp_l = lo;
      for (int c = 0; c <= bp; c++) begin
        if (c == bp) ready_out = 1;
        else begin
          valid_in = 1;
          position = 5'd17;
        end
        chk("push_valid", valid_out, 1);
        chk("push_ready", ready_in, 0);
        chk("push_k", k_out, exp_k);
        chk("push_l", l_out, exp_l);
        chk("push_i", i_out, exp_i);
        chk("push_z", z_out, exp_z);
        chk("push_pos", position_out, exp_pos);
        chk("push_addr", addr_out, exp_addr);
        chk("push_drops", drop_cnt, exp_drops);
        if (c == bp) valid_in = 0;
        @(negedge clk);
      end
      valid_in = 0;
      chk("release_valid", valid_out, 0);
      chk("release_ready", ready_in, 1);
    end
  endtask

  initial begin
    rst_n = 0; valid_in = 1; ready_out = 1; position = 5'd1; addr = 0;
    i_in = 0; z_in = 0; k_in = 0; l_in = 0; occ_k = 0; occ_l = 0;
    repeat (2) @(negedge clk);
    chk("rst_valid", valid_out, 0);
    chk("rst_ready", ready_in, 0);
    chk("rst_drops", drop_cnt, 0);
    chk("rst_k", k_out, 0);
    chk("rst_addr", addr_out, 0);
    rst_n = 1; valid_in = 0;
    @(negedge clk);
    chk("post_rst_ready", ready_in, 1);

    // A_MATCH
    run_set(1, 12'hABC, 5, 1, 2, 9, 3, 6, 0);
    chk("amatch_k", exp_k, 5);
    // C_DELETION: empty interval
    run_set(8, 12'h011, 4, 4, 0, 4, 4, 3, 0);
    // G_INSERTION z underflow, then valid
    run_set(11, 12'h022, 3, 0, 20, 30, 0, 0, 0);
    run_set(11, 12'h023, 3, 2, 20, 30, 0, 0, 0);
    // backpressure
    run_set(2, 12'h555, 7, 7, 0, 0, 10, 40, 5);
    // T_MATCH 9-bit carry
    run_set(13, 12'h0F0, 5, 5, 0, 0, 10, 100, 0);
    // undefined codes and STOP_2
    run_set(25, 12'h001, 5, 5, 0, 0, 1, 5, 0);
    run_set(18, 12'h002, 5, 5, 0, 0, 1, 5, 0);

    for (int n = 0; n < 80; n++) begin
      int ol;
      ol = $urandom_range(0, 255);
      run_set($urandom_range(0, 20), $urandom_range(0, 4095), $urandom_range(0, 6),
              $urandom_range(0, 6), $urandom_range(0, 255), $urandom_range(0, 255),
              $urandom_range(0, ol), ol, $urandom_range(0, 2));
    end

    for (int n = 0; n < 260; n++) run_set(17, n, 1, 1, 0, 0, 0, 0, 0);
    chk("sat_drops", drop_cnt, 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/update_param.md
Name: update_param

Overview:
- Pipeline stage directly downstream of the Occ-fetch stage (get_data_3) in the backtracking search datapath.
- Takes one search parameter set (i, z, k, l) together with its position code and the two Occ counts fetched for it (Occ at k-1 and Occ at l).
- Computes the child SA interval and the updated i/z, then either hands the child to the stack-push stage or drops it as empty or invalid.
- Buffers one result and holds it under backpressure through a valid/ready handshake.

Parameters:
- C_A, 8'd1, C-table count for base A.
- C_C, 8'd0, C-table count for base C; must be overridden per reference build.
- C_G, 8'd0, C-table count for base G; must be overridden per reference build.
- C_T, 8'd0, C-table count for base T; must be overridden per reference build.
- W, 8, width of i/z/k/l/occ fields; fixed at 8 in this revision.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- valid_in  in  1  upstream set is valid this cycle.
- ready_in  out  1  stage can accept a set this cycle.
- position  in  5  position code, values from the shared position define header.
- addr  in  12  parameter address tag; passed through unchanged.
- i_in, z_in, k_in, l_in  in  8 each  current parameters.
- occ_k  in  8  Occ(base, k-1), from the get_data_2 path.
- occ_l  in  8  Occ(base, l), i.e. data_2_out.
- valid_out  out  1  result is valid.
- ready_out  in  1  downstream accepts the result.
- position_out  out  5  registered copy of position.
- addr_out  out  12  registered copy of addr.
- i_out, z_out, k_out, l_out  out  8 each  child parameters.
- drop_cnt  out  8  count of dropped sets; saturates at 255.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - valid_out=0, ready_in=0, all data outputs=0, drop_cnt=0, FSM to IDLE.
  - Reset wins over any handshake in the same cycle.
  - Reset mid-operation discards the buffered set without counting a drop.
- FSM states: IDLE, CALC, HOLD.
  - IDLE: ready_in=1. valid_in&ready_in latches all inputs and goes to CALC.
  - CALC, one cycle, ready_in=0: computes the result.
    - Pushable result: registers outputs, sets valid_out=1, goes to HOLD.
    - Dropped result: increments drop_cnt (saturating), returns to IDLE with valid_out=0.
  - HOLD: valid_out=1 and outputs stable until ready_out=1.
    - On the ready_out=1 edge: valid_out=0, go to IDLE. ready_in stays 0 in HOLD, so there is no same-cycle accept.
- Latency and throughput:
  - Accept edge to valid_out high: 2 edges.
  - Throughput: one set per 3 cycles with ready_out tied high.
- Base select from position:
  - A_* selects C_A; C_* selects C_C; G_* selects C_G; T_* selects C_T.
- Arithmetic rules:
  - MATCH / SNP / DELETION: k' = Cb + occ_k + 1 and l' = Cb + occ_l, both computed at 9 bits.
  - INSERTION: k' = k_in, l' = l_in; Occ inputs are ignored.
  - i update: i-1 for MATCH, SNP and INSERTION; unchanged for DELETION.
  - z update: z-1 for SNP, INSERTION and DELETION; unchanged for MATCH.
- Drop conditions (any one drops the set):
  - k' > l' (empty interval).
  - k' or l' exceeds 255 (9-bit carry).
  - z_in=0 where z is decremented.
  - i_in=0 where i is decremented.
  - position is NONE, STOP_1, STOP_2, or any undefined code.
- Outputs are held at their last values whenever valid_out=0.

Test Plan:
- Reset: hold rst_n=0 for 2 clocks with valid_in=1 -> valid_out=0, ready_in=0, drop_cnt=0; ready_in=1 the cycle after rst_n rises.
- A_MATCH (C_A=1): i=5, z=1, k=2, l=9, occ_k=3, occ_l=6, ready_out=1 -> valid_out high 2 edges after accept; k_out=5, l_out=7, i_out=4, z_out=1; addr passed unchanged.
- C_DELETION (C_C=10): k=0, l=4, occ_k=4, occ_l=3 -> k'=15, l'=13, so dropped; no valid_out, drop_cnt=1, back in IDLE.
- G_INSERTION: i=3, z=0 -> dropped (z underflow). Same set with z=2 -> k_out=k_in, l_out=l_in, i_out=2, z_out=1.
- Backpressure: ready_out=0 for 5 cycles after valid_out rises -> outputs stable, ready_in=0, a new valid_in is not accepted; ready_out=1 -> valid_out falls next edge, ready_in=1.
- Saturation and overflow: 260 STOP_1 sets -> drop_cnt=255. Also T_MATCH with C_T=200 and occ_l=100 -> dropped (9-bit carry).
